sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//  Serial-in/parallel-out receiver; the deserialising counterpart of the team's PISO transmitter.
//  Accepts one bit per valid/ready handshake, MSB first, and assembles WIDTH-bit words.
//  Presents each word on a registered valid/ready parallel port.
//  Holds one output word while the next word shifts in; backpressures the serial side only when both are full.
// PARAMETERS
//  width  4  data word width in bits, >= 2
// PORTS
//  clk_rx_in      in   1      single clock; all logic on its rising edge
//  rst            in   1      synchronous reset, active-high
//  data_i         in   1      serial data bit
//  valid_in       in   1      serial bit valid (upstream)
//  ready_out      out  1      serial bit accepted when valid_in && ready_out
//  data_o         out  width  assembled parallel word
//  valid_out      out  1      data_o valid (downstream)
//  ready_in       in   1      downstream accepts word when valid_out && ready_in
//  parity_err_o   out  1      parity error flag qualified by valid_out
// BEHAVIOUR
//  Reset: synchronous; while rst=1 at a clock edge: shift_q=0, bit_cnt=0, state=EMPTY, data_o=0,
//  valid_out=0, parity_err_o=0; ready_out forced 0 while rst=1 (combinational).
//  Frame length FRAME = width (width+1 with SIPO_PARITY_EN); bit_cnt is 0..FRAME-1, width $clog2(FRAME+1).
//  Bit accept: on valid_in && ready_out, shift_q <= {shift_q[width-2:0], data_i}; bit_cnt++ (MSB first).
//  Gaps (valid_in=0) hold shift_q and bit_cnt unchanged; no timeout.
//  Last bit (bit_cnt==FRAME-1 && accept): bit_cnt wraps to 0; the completed word
//   ({shift_q[width-2:0],data_i} when no parity) loads data_o; valid_out=1 on the next cycle (latency 1 clk).
//  Output FSM, 2 states:
//   EMPTY: valid_out=0. Word completes -> HOLD.
//   HOLD : valid_out=1, data_o stable. ready_in && no word completing -> EMPTY.
//          ready_in && word completing -> stay HOLD, data_o replaced by new word (back-to-back, no bubble).
//          !ready_in -> stay HOLD, data_o and parity_err_o stable.
//  ready_out = !rst && !(bit_cnt==FRAME-1 && state==HOLD && !ready_in).
//   Final bit of a frame stalls only while the held word is unconsumed; bits 0..FRAME-2 always accepted.
//   ready_out may depend combinationally on ready_in; no combinational path from valid_in to ready_out.
//  No overrun possible: completed words are never dropped or overwritten before acceptance.
//  Reset mid-frame discards partial bits and any held word; the next accepted bit is bit 0 of a new frame.
// CONFIGURATION
//  SIPO_PARITY_EN defined: FRAME=width+1; bit FRAME-1 is an even-parity bit over the width data bits.
//   The parity bit is not shifted into shift_q; data_o = shift_q at frame end.
//   parity_err_o = (^shift_q ^ data_i), loaded with data_o, held with it, cleared on reset.
//  SIPO_PARITY_EN undefined: FRAME=width; parity_err_o tied 0. Port list is identical in both builds.
// TESTING
//  (width=4, ready_in=1) Send bits 1,0,1,1 on consecutive cycles -> data_o=4'b1011, valid_out=1 for exactly one cycle, the cycle after the 4th accept.
//  ready_in=0; send 1011 then 0110 -> word 1 held; bits 0,1,1 accepted; ready_out=0 on the 4th bit.
//   Raise ready_in -> 0110 loads the same cycle; valid_out stays 1; no word lost.
//  valid_in toggled 1,0,0,1,0,1,1 carrying bits 1,0,1,1 -> data_o=4'b1011; gaps ignored.
//  Send bits 1,1, assert rst for 1 clk, then send 0,1,0,1 -> data_o=4'b0101; valid_out=0 throughout reset.
//  Continuous stream of 1100,0011,1010 with ready_in=1 -> three words, valid_out pulses every 4 cycles, ready_out never drops.
//  SIPO_PARITY_EN: send 1,0,1,1,1 -> data_o=1011, parity_err_o=0; send 1,0,1,1,0 -> parity_err_o=1.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles MSB-first bits into width-bit words on a valid/ready port.
// Optional even-parity frame bit enabled by defining SIPO_PARITY_EN.
module sipo_rx #(
    parameter int width = 4
) (
    input  logic             clk_rx_in,
    input  logic             rst,
    input  logic             data_i,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [width-1:0] data_o,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             parity_err_o
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = width + 1;
`else
    localparam int FRAME = width;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [width-1:0]   shift_q;
    logic [width-1:0]   shift_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic [width-1:0]   data_q;
    logic [width-1:0]   data_d;
    logic               perr_q;
    logic               perr_d;

    logic               last_bit_s;
    logic               accept_s;
    logic               word_done_s;
    logic [width-1:0]   word_s;
    logic               word_perr_s;

`ifdef SIPO_PARITY_EN
    function automatic logic odd_ones(input logic [width-1:0] v);
        return ^v;
    endfunction
`endif

    // Only the final frame bit can stall, and only while the held word is still unconsumed.
    assign last_bit_s  = (bit_cnt_q == LAST_CNT);
    assign ready_out   = !rst && !(last_bit_s && (state_q == HOLD) && !ready_in);
    assign accept_s    = valid_in && ready_out;
    assign word_done_s = accept_s && last_bit_s;

`ifdef SIPO_PARITY_EN
    assign word_s      = shift_q;
    assign word_perr_s = odd_ones(shift_q) ^ data_i;
`else
    assign word_s      = {shift_q[width-2:0], data_i};
    assign word_perr_s = 1'b0;
`endif

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        perr_d    = perr_q;
        if (accept_s) begin
            if (last_bit_s) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
`ifdef SIPO_PARITY_EN
            // The parity bit is checked, never stored.
            if (!last_bit_s) begin
                shift_d = {shift_q[width-2:0], data_i};
            end else begin
                shift_d = shift_q;
            end
`else
            shift_d = {shift_q[width-2:0], data_i};
`endif
        end else begin
            shift_d   = shift_q;
            bit_cnt_d = bit_cnt_q;
        end
        if (word_done_s) begin
            data_d = word_s;
            perr_d = word_perr_s;
        end else begin
            data_d = data_q;
            perr_d = perr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (word_done_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = EMPTY;
                end
            end
            HOLD: begin
                if (ready_in && !word_done_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_rx_in) begin
        if (rst) begin
            state_q   <= EMPTY;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_out = (state_q == HOLD);
`ifdef SIPO_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus a random run against a word-level scoreboard.
module tb_sipo_rx;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_i = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [W-1:0] data_o;
    logic         valid_out;
    logic         ready_in = 1'b1;
    logic         parity_err_o;

    sipo_rx #(.width(W)) dut (
        .clk_rx_in    (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_o       (data_o),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic         ro_s, vo_s, pe_s, acc_s, hs_s;
    logic [W-1:0] do_s;
    int           vo_cnt = 0;
    int           ro_low_cnt = 0;

    bit           cur[$];
    logic [W-1:0] exp_data[$];
    logic         exp_pe[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just before the rising edge, update the reference, then return at the falling edge.
    task automatic tick();
        logic         exp_ro;
        logic [W-1:0] w;
        logic         x;
        #4;
        ro_s  = ready_out;
        vo_s  = valid_out;
        do_s  = data_o;
        pe_s  = parity_err_o;
        acc_s = valid_in && ready_out;
        hs_s  = valid_out && ready_in;
        if (vo_s) vo_cnt++;
        if (rst) begin
            chk("ready_out_in_reset", ro_s, 0);
        end else begin
            if (!ro_s) ro_low_cnt++;
            exp_ro = !((cur.size() == FRAME - 1) && (exp_data.size() != 0) && !ready_in);
            chk("ready_out", ro_s, exp_ro);
            chk("valid_out", vo_s, exp_data.size() != 0);
            if (hs_s && exp_data.size() != 0) begin
                chk("word_data", do_s, exp_data[0]);
                chk("word_parity_err", pe_s, exp_pe[0]);
                void'(exp_data.pop_front());
                void'(exp_pe.pop_front());
            end
            if (acc_s) begin
                cur.push_back(data_i);
                if (cur.size() == FRAME) begin
                    w = '0;
                    for (int j = 0; j < W; j++) w[W-1-j] = cur[j];
                    x = 1'b0;
`ifdef SIPO_PARITY_EN
                    for (int j = 0; j < FRAME; j++) x = x ^ cur[j];
`endif
                    exp_data.push_back(w);
                    exp_pe.push_back(x);
                    cur.delete();
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            cur.delete();
            exp_data.delete();
            exp_pe.delete();
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        valid_in = 1'b1;
        data_i   = b;
        do begin
            tick();
            n++;
        end while (!acc_s && n < 64);
        chk("bit_accept", acc_s, 1);
    endtask

    function automatic logic [FRAME-1:0] mk(input logic [W-1:0] w);
`ifdef SIPO_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic send_frame(input logic [FRAME-1:0] f);
        for (int i = FRAME - 1; i >= 0; i--) send_bit(f[i]);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [FRAME-1:0] f2;
        logic [6:0]       vpat;
        logic [3:0]       dbits;
        int               k;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_valid_out", vo_s, 0);
        chk("reset_data_o", do_s, 0);
        chk("reset_parity_err", pe_s, 0);

        // Single word, consumed immediately: valid for exactly one cycle
        ready_in = 1'b1;
        send_frame(mk(4'b1011));
        tick();
        chk("t1_valid", vo_s, 1);
        chk("t1_data", do_s, 4'b1011);
        tick();
        chk("t1_valid_one_cycle", vo_s, 0);

        // Backpressure: second frame stalls only on its final bit
        ready_in = 1'b0;
        send_frame(mk(4'b1011));
        f2 = mk(4'b0110);
        for (int i = FRAME - 1; i >= 1; i--) send_bit(f2[i]);
        valid_in = 1'b1;
        data_i   = f2[0];
        tick();
        chk("t2_stall_ready", ro_s, 0);
        chk("t2_stall_accept", acc_s, 0);
        chk("t2_hold_data", do_s, 4'b1011);
        tick();
        chk("t2_still_stalled", acc_s, 0);
        chk("t2_still_valid", vo_s, 1);
        ready_in = 1'b1;
        tick();
        chk("t2_release_accept", acc_s, 1);
        chk("t2_release_consume", hs_s, 1);
        valid_in = 1'b0;
        tick();
        chk("t2_b2b_valid", vo_s, 1);
        chk("t2_b2b_data", do_s, 4'b0110);
        tick();
        chk("t2_drained", vo_s, 0);

        // Gaps in valid_in are ignored
        vpat  = 7'b1001011;
        dbits = 4'b1011;
        k     = 3;
        for (int i = 6; i >= 0; i--) begin
            valid_in = vpat[i];
            data_i   = vpat[i] ? dbits[k] : 1'($urandom_range(0, 1));
            tick();
            chk("t3_gap_accept", acc_s, vpat[i]);
            if (vpat[i]) k--;
        end
`ifdef SIPO_PARITY_EN
        send_bit(1'b1);
`endif
        valid_in = 1'b0;
        tick();
        chk("t3_valid", vo_s, 1);
        chk("t3_data", do_s, 4'b1011);
        idle(2);

        // Reset mid-frame discards partial bits
        send_bit(1'b1);
        send_bit(1'b1);
        valid_in = 1'b0;
        rst = 1'b1;
        tick();
        chk("t4_valid_in_reset", vo_s, 0);
        rst = 1'b0;
        tick();
        chk("t4_valid_after_reset", vo_s, 0);
        chk("t4_data_after_reset", do_s, 0);
        send_frame(mk(4'b0101));
        tick();
        chk("t4_valid", vo_s, 1);
        chk("t4_data", do_s, 4'b0101);
        idle(2);

        // Continuous stream, no backpressure
        vo_cnt     = 0;
        ro_low_cnt = 0;
        send_frame(mk(4'b1100));
        send_frame(mk(4'b0011));
        send_frame(mk(4'b1010));
        tick();
        chk("t5_valid_pulses", vo_cnt, 3);
        chk("t5_ready_never_low", ro_low_cnt, 0);
        idle(2);

`ifdef SIPO_PARITY_EN
        // Even parity over the data bits
        send_frame(5'b10111);
        tick();
        chk("t6_par_ok_data", do_s, 4'b1011);
        chk("t6_par_ok_err", pe_s, 0);
        send_frame(5'b10110);
        tick();
        chk("t6_par_bad_data", do_s, 4'b1011);
        chk("t6_par_bad_err", pe_s, 1);
        idle(2);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            valid_in = ($urandom_range(0, 9) < 7);
            data_i   = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst      = 1'b0;
        ready_in = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
